// File: rtl/huff_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : huff_seq_ctrl
//  Description : Run-level sequencer for the Huffman compression pipeline.
//                Clears the stages, then starts symbol counter, tree builder,
//                code generator and serial output stage in order. Each stage
//                gets a one-cycle start pulse and the sequencer waits for
//                its done level. Reports busy/done/error status and counts
//                run cycles.
//                Optional per-stage watchdog: define HUFF_SEQ_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module huff_seq_ctrl #(
    parameter int TO_CYCLES = 50000,
    parameter int CNT_W     = 32
) (
    input  logic             Clk_in,
    input  logic             n_Rst,
    input  logic             Go,
    input  logic             Abort,
    output logic             Stage_nrst,
    output logic             Start_cnt,
    output logic             Start_tree,
    output logic             Start_code,
    output logic             Start_out,
    input  logic             Done_cnt,
    input  logic             Done_tree,
    input  logic             Done_code,
    input  logic             Fin,
    output logic             Busy,
    output logic             Done,
    output logic             Err,
    output logic [1:0]       Err_stage,
    output logic [2:0]       Phase,
    output logic [CNT_W-1:0] Cycles
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_CNT  = 3'd2,
        ST_TREE = 3'd3,
        ST_CODE = 3'd4,
        ST_OUT  = 3'd5,
        ST_DONE = 3'd6,
        ST_ERR  = 3'd7
    } state_t;

    // A watchdog shorter than two cycles could never see a wait cycle.
    if (TO_CYCLES < 2) begin : g_bad_to_cycles
        $error("huff_seq_ctrl: TO_CYCLES must be at least 2");
    end

    state_t           state;
    state_t           state_nxt;
    state_t           stage_succ;
    logic             entry;       // first cycle after a state change
    logic             in_stage;
    logic             stage_done;
    logic [1:0]       stage_idx;
    logic [CNT_W-1:0] cycles;

`ifdef HUFF_SEQ_TIMEOUT_EN
    localparam int               WD_W    = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TO_CYCLES - 1);

    // Cycles since stage entry; equals the index of the current wait cycle.
    logic [WD_W-1:0] wd;
    logic            timeout_hit;
    logic            err;
    logic [1:0]      err_stage;
`endif

    // Next-state and output decode
    always_comb begin
        stage_done = 1'b0;
        stage_idx  = 2'd0;
        stage_succ = ST_IDLE;
        in_stage   = 1'b0;
        case (state)
            ST_CNT:  begin in_stage = 1'b1; stage_done = Done_cnt;  stage_idx = 2'd0; stage_succ = ST_TREE; end
            ST_TREE: begin in_stage = 1'b1; stage_done = Done_tree; stage_idx = 2'd1; stage_succ = ST_CODE; end
            ST_CODE: begin in_stage = 1'b1; stage_done = Done_code; stage_idx = 2'd2; stage_succ = ST_OUT;  end
            ST_OUT:  begin in_stage = 1'b1; stage_done = Fin;       stage_idx = 2'd3; stage_succ = ST_DONE; end
            default: ;
        endcase

`ifdef HUFF_SEQ_TIMEOUT_EN
        // Done and Abort both outrank the watchdog.
        timeout_hit = in_stage && !entry && !stage_done && !Abort && (wd == WD_LAST);
`endif

        state_nxt = state;
        if ((state != ST_IDLE) && Abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (Go) state_nxt = ST_CLR;
                ST_CLR:  state_nxt = ST_CNT;
                ST_CNT, ST_TREE, ST_CODE, ST_OUT: begin
                    // Done levels are ignored during the entry (start) cycle.
                    if (!entry && stage_done) begin
                        state_nxt = stage_succ;
                    end
`ifdef HUFF_SEQ_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state_nxt = ST_ERR;
                    end
`endif
                end
                // Go still high at completion chains straight into the next
                // run's clear cycle so runs stay back-to-back.
                ST_DONE: state_nxt = Go ? ST_CLR : ST_IDLE;
`ifdef HUFF_SEQ_TIMEOUT_EN
                ST_ERR:  if (!Go) state_nxt = ST_IDLE;
`else
                ST_ERR:  state_nxt = ST_IDLE;
`endif
                default: state_nxt = ST_IDLE;
            endcase
        end

        Stage_nrst = (state != ST_CLR);
        Start_cnt  = (state == ST_CNT)  && entry && !Abort;
        Start_tree = (state == ST_TREE) && entry && !Abort;
        Start_code = (state == ST_CODE) && entry && !Abort;
        Start_out  = (state == ST_OUT)  && entry && !Abort;
        Busy       = (state != ST_IDLE);
        Done       = (state == ST_DONE) && !Abort;
        Phase      = state;
    end

    // State register and entry-cycle flag
    always_ff @(posedge Clk_in or negedge n_Rst) begin
        if (!n_Rst) begin
            state <= ST_IDLE;
            entry <= 1'b0;
        end else begin
            state <= state_nxt;
            entry <= (state_nxt != state);
        end
    end

    // Run cycle counter: restarts at 1 in CLR, counts stage cycles, saturates
    always_ff @(posedge Clk_in or negedge n_Rst) begin
        if (!n_Rst) begin
            cycles <= '0;
        end else if (!Abort) begin
            if (state == ST_CLR) begin
                cycles <= CNT_W'(1);
            end else if (in_stage && (cycles != {CNT_W{1'b1}})) begin
                cycles <= cycles + CNT_W'(1);
            end
        end
    end

    assign Cycles = cycles;

`ifdef HUFF_SEQ_TIMEOUT_EN
    // Watchdog: zero on every state change, counts while a stage is held
    always_ff @(posedge Clk_in or negedge n_Rst) begin
        if (!n_Rst) begin
            wd <= '0;
        end else if (in_stage && (state_nxt == state)) begin
            wd <= wd + WD_W'(1);
        end else begin
            wd <= '0;
        end
    end

    // Sticky timeout flag and offending stage, cleared by the next CLR
    always_ff @(posedge Clk_in or negedge n_Rst) begin
        if (!n_Rst) begin
            err       <= 1'b0;
            err_stage <= 2'd0;
        end else if ((state == ST_CLR) && !Abort) begin
            err       <= 1'b0;
            err_stage <= 2'd0;
        end else if (timeout_hit) begin
            err       <= 1'b1;
            err_stage <= stage_idx;
        end
    end

    assign Err       = err;
    assign Err_stage = err_stage;
`else
    assign Err       = 1'b0;
    assign Err_stage = 2'd0;
`endif

endmodule
`default_nettype wire
